// File: rtl/draw_pkg.sv
// Shared types and defaults for the pixel sink.
package draw_pkg;

  typedef enum logic [1:0] {
    CMD_FLUSH  = 2'd0,
    CMD_FINISH = 2'd1,
    CMD_CLEAR  = 2'd2,
    CMD_RSVD   = 2'd3
  } cmd_op_e;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  localparam int unsigned DEFAULT_WIDTH    = 200;
  localparam int unsigned DEFAULT_HEIGHT   = 200;
  localparam int unsigned DEFAULT_MAXLIMIT = 1000;

endpackage

// File: rtl/draw_fb_ram.sv
// Frame buffer: simple dual-port RAM, read-first, one cycle read latency.
module draw_fb_ram #(
  parameter int unsigned DEPTH  = 12,
  parameter int unsigned DATA_W = 10,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port; the array itself is not reset, the clear sweep zeroes it.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port; non-blocking update gives old data on a same-address write.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/draw_pixel_sink.sv
// Pixel-drawing sink: shades incoming pixels into a frame buffer, handles
// flush/finish/clear commands and exposes a synchronous read port.
module draw_pixel_sink
  import draw_pkg::*;
#(
  parameter int unsigned WIDTH  = DEFAULT_WIDTH,
  parameter int unsigned HEIGHT = DEFAULT_HEIGHT,
  parameter int unsigned CNT_W  = 10,
  parameter int unsigned ADDR_W = $clog2(WIDTH * HEIGHT)
) (
  input  logic              sync_clk,
  input  logic              sync_rst,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [15:0]       pix_x,
  input  logic [15:0]       pix_y,
  input  logic [31:0]       pix_n,
  input  logic [31:0]       pix_min,
  input  logic [31:0]       pix_max,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [CNT_W-1:0]  rd_data,
  output logic              busy,
  output logic              flush_pulse,
  output logic              frame_done,
  output logic [15:0]       frame_cnt,
  output logic [31:0]       pix_cnt,
  output logic [15:0]       drop_cnt
);

  localparam logic [15:0]       WIDTH_XY  = 16'(WIDTH);
  localparam logic [15:0]       HEIGHT_XY = 16'(HEIGHT);
  localparam logic [ADDR_W-1:0] WIDTH_A   = ADDR_W'(WIDTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);
  localparam logic [ADDR_W-1:0] ONE_A     = ADDR_W'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  cmd_op_e           op;

  logic              in_range;
  logic [ADDR_W-1:0] pix_addr;
  logic [CNT_W-1:0]  shade;
  logic              pix_fire, cmd_fire;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [CNT_W-1:0]  ram_wdata;

  logic              flush_pulse_q, flush_pulse_d;
  logic              frame_done_q, frame_done_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic [31:0]       pix_cnt_q, pix_cnt_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;

  assign op       = cmd_op_e'(cmd_op);
  assign in_range = (pix_x < WIDTH_XY) && (pix_y < HEIGHT_XY);
  // Address is only meaningful once in_range holds; truncation is harmless then.
  assign pix_addr = ADDR_W'(pix_y) * WIDTH_A + ADDR_W'(pix_x);
  // Outside [min, max) is drawn as background (shade 0).
  assign shade    = (pix_n < pix_min || pix_n >= pix_max) ? '0 : pix_n[CNT_W-1:0];
  assign pix_fire = pix_valid && pix_ready;
  assign cmd_fire = cmd_valid && cmd_ready;

  // State register and clear-sweep address.
  always_ff @(posedge sync_clk) begin
    if (sync_rst) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // Next state, handshake readies and frame buffer write mux.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    pix_ready  = 1'b0;
    cmd_ready  = 1'b0;
    busy       = 1'b0;
    ram_we     = 1'b0;
    ram_waddr  = pix_addr;
    ram_wdata  = shade;
    unique case (state_q)
      ST_CLEAR: begin
        busy       = 1'b1;
        ram_we     = 1'b1;
        ram_waddr  = clr_addr_q;
        ram_wdata  = '0;
        clr_addr_d = clr_addr_q + ONE_A;
        if (clr_addr_q == LAST_ADDR) begin
          state_d    = ST_IDLE;
          clr_addr_d = '0;
        end
      end
      ST_IDLE: begin
        pix_ready = 1'b1;
        // A pixel wins a same-cycle collision; the command waits.
        cmd_ready = !pix_valid;
        ram_we    = pix_valid && in_range;
        if (cmd_valid && !pix_valid && op == CMD_CLEAR) begin
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
        end
      end
      default: begin
        state_d    = ST_CLEAR;
        clr_addr_d = '0;
      end
    endcase
  end

  // Next-state for status counters and flags.
  always_comb begin
    flush_pulse_d = cmd_fire && (op == CMD_FLUSH);
    frame_done_d  = frame_done_q;
    frame_cnt_d   = frame_cnt_q;
    pix_cnt_d     = pix_cnt_q;
    drop_cnt_d    = drop_cnt_q;
    if (pix_fire) begin
      if (in_range) begin
        pix_cnt_d = pix_cnt_q + 32'd1;
      end else if (drop_cnt_q != 16'hFFFF) begin
        drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end
    if (cmd_fire) begin
      case (op)
        CMD_FINISH: begin
          frame_done_d = 1'b1;
          frame_cnt_d  = frame_cnt_q + 16'd1;
        end
        CMD_CLEAR: begin
          frame_done_d = 1'b0;
          pix_cnt_d    = '0;
        end
        default: ;
      endcase
    end
  end

  // Status registers; drop_cnt deliberately survives a CLEAR command.
  always_ff @(posedge sync_clk) begin
    if (sync_rst) begin
      flush_pulse_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_cnt_q   <= '0;
      pix_cnt_q     <= '0;
      drop_cnt_q    <= '0;
    end else begin
      flush_pulse_q <= flush_pulse_d;
      frame_done_q  <= frame_done_d;
      frame_cnt_q   <= frame_cnt_d;
      pix_cnt_q     <= pix_cnt_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  assign flush_pulse = flush_pulse_q;
  assign frame_done  = frame_done_q;
  assign frame_cnt   = frame_cnt_q;
  assign pix_cnt     = pix_cnt_q;
  assign drop_cnt    = drop_cnt_q;

  draw_fb_ram #(
    .DEPTH  (WIDTH * HEIGHT),
    .DATA_W (CNT_W),
    .ADDR_W (ADDR_W)
  ) u_fb (
    .clk   (sync_clk),
    .rst   (sync_rst),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_draw_pixel_sink.sv
// Directed bench: small 4x3 instance for feature tests, 200x200 for a full frame.
module tb_draw_pixel_sink;
  import draw_pkg::*;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [31:0] n;
    logic [31:0] mn;
    logic [31:0] mx;
    logic [3:0]  a;
    logic [9:0]  exp;
  } pv_t;

  int errors = 0;
  int checks = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic sync_rst;

  // Small instance.
  logic        pix_valid, pix_ready, cmd_valid, cmd_ready, rd_en, busy, flush_pulse, frame_done;
  logic [15:0] pix_x, pix_y, frame_cnt, drop_cnt;
  logic [31:0] pix_n, pix_min, pix_max, pix_cnt;
  logic [1:0]  cmd_op;
  logic [3:0]  rd_addr;
  logic [9:0]  rd_data;

  // Full-size instance.
  logic        b_pix_valid, b_pix_ready, b_cmd_valid, b_cmd_ready, b_rd_en, b_busy;
  logic        b_flush_pulse, b_frame_done;
  logic [15:0] b_pix_x, b_pix_y, b_frame_cnt, b_drop_cnt;
  logic [31:0] b_pix_n, b_pix_min, b_pix_max, b_pix_cnt;
  logic [1:0]  b_cmd_op;
  logic [15:0] b_rd_addr;
  logic [9:0]  b_rd_data;

  draw_pixel_sink #(.WIDTH(4), .HEIGHT(3)) dut (
    .sync_clk(clk), .sync_rst(sync_rst),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y),
    .pix_n(pix_n), .pix_min(pix_min), .pix_max(pix_max),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .flush_pulse(flush_pulse), .frame_done(frame_done),
    .frame_cnt(frame_cnt), .pix_cnt(pix_cnt), .drop_cnt(drop_cnt)
  );

  draw_pixel_sink #(.WIDTH(DEFAULT_WIDTH), .HEIGHT(DEFAULT_HEIGHT)) dut_big (
    .sync_clk(clk), .sync_rst(sync_rst),
    .pix_valid(b_pix_valid), .pix_ready(b_pix_ready), .pix_x(b_pix_x), .pix_y(b_pix_y),
    .pix_n(b_pix_n), .pix_min(b_pix_min), .pix_max(b_pix_max),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_op(b_cmd_op),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
    .busy(b_busy), .flush_pulse(b_flush_pulse), .frame_done(b_frame_done),
    .frame_cnt(b_frame_cnt), .pix_cnt(b_pix_cnt), .drop_cnt(b_drop_cnt)
  );

  task automatic send_pix(input logic [15:0] x, input logic [15:0] y, input logic [31:0] n,
                          input logic [31:0] mn, input logic [31:0] mx);
    int cyc;
    @(negedge clk);
    pix_x = x; pix_y = y; pix_n = n; pix_min = mn; pix_max = mx; pix_valid = 1'b1;
    cyc = 0;
    #1;
    while (!pix_ready && cyc < 50) begin
      @(negedge clk); #1; cyc++;
    end
    if (!pix_ready) begin
      checks++; errors++;
      $display("FAIL pix_handshake_timeout ready=%0b required=1", pix_ready);
    end
    @(posedge clk); #1;
    pix_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [1:0] op);
    int cyc;
    @(negedge clk);
    cmd_op = op; cmd_valid = 1'b1;
    cyc = 0;
    #1;
    while (!cmd_ready && cyc < 50) begin
      @(negedge clk); #1; cyc++;
    end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL cmd_handshake_timeout ready=%0b required=1", cmd_ready);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [9:0] d);
    @(negedge clk);
    rd_en = 1'b1; rd_addr = a;
    @(posedge clk); #1;
    rd_en = 1'b0;
    @(negedge clk);
    d = rd_data;
  endtask

  task automatic test_reset();
    int cnt;
    logic rdy_bad;
    logic [9:0] d;
    sync_rst = 1'b1;
    pix_valid = 1'b0; cmd_valid = 1'b0; rd_en = 1'b0; rd_addr = '0; cmd_op = '0;
    pix_x = '0; pix_y = '0; pix_n = '0; pix_min = '0; pix_max = '0;
    b_pix_valid = 1'b0; b_cmd_valid = 1'b0; b_rd_en = 1'b0; b_rd_addr = '0; b_cmd_op = '0;
    b_pix_x = '0; b_pix_y = '0; b_pix_n = '0; b_pix_min = 32'd1; b_pix_max = 32'd1000;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, pix_ready, cmd_ready, flush_pulse, frame_done} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_flags got=%b required=10000",
               {busy, pix_ready, cmd_ready, flush_pulse, frame_done});
    end
    checks++;
    if ({frame_cnt, pix_cnt, drop_cnt, rd_data} !== '0) begin
      errors++;
      $display("FAIL reset_counters frame_cnt=%0h pix_cnt=%0h drop_cnt=%0h rd_data=%0h required=0",
               frame_cnt, pix_cnt, drop_cnt, rd_data);
    end
    sync_rst = 1'b0;
    cnt = 0; rdy_bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      cnt++;
      if (pix_ready || cmd_ready) rdy_bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (cnt != 12) begin
      errors++; $display("FAIL reset_busy_cycles got=%0d required=12", cnt);
    end
    checks++;
    if (rdy_bad !== 1'b0 || pix_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready ready_during_clear=%0b pix_ready=%0b required=0/1",
               rdy_bad, pix_ready);
    end
    for (int a = 0; a < 12; a++) begin
      rd(4'(a), d);
      checks++;
      if (d !== 10'd0) begin
        errors++; $display("FAIL reset_mem addr=%0d got=%0h required=0", a, d);
      end
    end
  endtask

  task automatic test_pixel_write();
    pv_t tbl [8];
    logic [9:0] d;
    tbl = '{
      '{16'd2, 16'd1, 32'd37,           32'd1, 32'd1000,         4'd6,  10'd37},
      '{16'd0, 16'd0, 32'd5,            32'd1, 32'd1000,         4'd0,  10'd5},
      '{16'd0, 16'd0, 32'd1000,         32'd1, 32'd1000,         4'd0,  10'd0},
      '{16'd3, 16'd2, 32'd999,          32'd1, 32'd1000,         4'd11, 10'd999},
      '{16'd3, 16'd2, 32'd0,            32'd1, 32'd1000,         4'd11, 10'd0},
      '{16'd1, 16'd0, 32'd4,            32'd4, 32'd1000,         4'd1,  10'd4},
      '{16'd1, 16'd0, 32'd3,            32'd4, 32'd1000,         4'd1,  10'd0},
      '{16'd2, 16'd0, 32'h8000_0005,    32'd1, 32'hFFFF_FFFF,    4'd2,  10'd5}
    };
    for (int i = 0; i < 8; i++) begin
      send_pix(tbl[i].x, tbl[i].y, tbl[i].n, tbl[i].mn, tbl[i].mx);
      rd(tbl[i].a, d);
      checks++;
      if (d !== tbl[i].exp) begin
        errors++;
        $display("FAIL pixel_write[%0d] addr=%0d got=%0d required=%0d", i, tbl[i].a, d,
                 tbl[i].exp);
      end
      if (i == 0) begin
        checks++;
        if (pix_cnt !== 32'd1) begin
          errors++; $display("FAIL pix_cnt_first got=%0d required=1", pix_cnt);
        end
      end
    end
    checks++;
    if (pix_cnt !== 32'd8) begin
      errors++; $display("FAIL pix_cnt_after_writes got=%0d required=8", pix_cnt);
    end
  endtask

  task automatic test_out_of_range();
    logic [9:0] d;
    send_pix(16'd4, 16'd0, 32'd7, 32'd1, 32'd1000);
    send_pix(16'd0, 16'd3, 32'd7, 32'd1, 32'd1000);
    @(negedge clk);
    checks++;
    if (drop_cnt !== 16'd2 || pix_cnt !== 32'd8) begin
      errors++;
      $display("FAIL oor_counts drop_cnt=%0d pix_cnt=%0d required=2/8", drop_cnt, pix_cnt);
    end
    rd(4'd4, d);
    checks++;
    if (d !== 10'd0) begin
      errors++; $display("FAIL oor_mem_alias addr=4 got=%0d required=0", d);
    end
    rd(4'd6, d);
    checks++;
    if (d !== 10'd37) begin
      errors++; $display("FAIL oor_mem_keep addr=6 got=%0d required=37", d);
    end
    // Preload the drop counter near its ceiling.
    @(negedge clk);
    force dut.drop_cnt_q = 16'hFFFE;
    @(negedge clk);
    @(negedge clk);
    release dut.drop_cnt_q;
    send_pix(16'd9, 16'd0, 32'd7, 32'd1, 32'd1000);
    @(negedge clk);
    checks++;
    if (drop_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL drop_cnt_reach_max got=%0h required=ffff", drop_cnt);
    end
    send_pix(16'd0, 16'd200, 32'd7, 32'd1, 32'd1000);
    @(negedge clk);
    checks++;
    if (drop_cnt !== 16'hFFFF || pix_cnt !== 32'd8) begin
      errors++;
      $display("FAIL drop_cnt_saturate drop_cnt=%0h pix_cnt=%0d required=ffff/8", drop_cnt,
               pix_cnt);
    end
  endtask

  task automatic test_commands();
    int cnt;
    send_cmd(2'd0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (flush_pulse) cnt++;
    end
    checks++;
    if (cnt != 1) begin
      errors++; $display("FAIL flush_pulse_cycles got=%0d required=1", cnt);
    end
    send_cmd(2'd1);
    send_cmd(2'd1);
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b1 || frame_cnt !== 16'd2) begin
      errors++;
      $display("FAIL finish_twice frame_done=%0b frame_cnt=%0d required=1/2", frame_done,
               frame_cnt);
    end
    send_cmd(2'd3);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (flush_pulse) cnt++;
    end
    checks++;
    if (cnt != 0 || frame_done !== 1'b1 || frame_cnt !== 16'd2 || pix_cnt !== 32'd8 ||
        busy !== 1'b0) begin
      errors++;
      $display("FAIL reserved_op flush=%0d done=%0b frame_cnt=%0d pix_cnt=%0d busy=%0b",
               cnt, frame_done, frame_cnt, pix_cnt, busy);
    end
  endtask

  task automatic test_collision();
    logic [9:0] d;
    @(negedge clk);
    pix_x = 16'd3; pix_y = 16'd0; pix_n = 32'd9; pix_min = 32'd1; pix_max = 32'd1000;
    pix_valid = 1'b1; cmd_op = 2'd1; cmd_valid = 1'b1;
    #1;
    checks++;
    if ({pix_ready, cmd_ready} !== 2'b10) begin
      errors++; $display("FAIL collision_ready got=%b required=10", {pix_ready, cmd_ready});
    end
    @(posedge clk); #1;
    pix_valid = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || frame_cnt !== 16'd2 || pix_cnt !== 32'd9) begin
      errors++;
      $display("FAIL collision_pixel_first cmd_ready=%0b frame_cnt=%0d pix_cnt=%0d req=1/2/9",
               cmd_ready, frame_cnt, pix_cnt);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checks++;
    if (frame_cnt !== 16'd3) begin
      errors++; $display("FAIL collision_finish_next got=%0d required=3", frame_cnt);
    end
    rd(4'd3, d);
    checks++;
    if (d !== 10'd9) begin
      errors++; $display("FAIL collision_mem addr=3 got=%0d required=9", d);
    end
  endtask

  task automatic test_clear_midframe();
    int cnt;
    logic rdy_bad;
    logic [9:0] d;
    logic [9:0] exp;
    send_pix(16'd0, 16'd1, 32'd11, 32'd1, 32'd1000);
    send_pix(16'd1, 16'd1, 32'd12, 32'd1, 32'd1000);
    send_pix(16'd2, 16'd2, 32'd13, 32'd1, 32'd1000);
    send_pix(16'd3, 16'd1, 32'd14, 32'd1, 32'd1000);
    send_pix(16'd0, 16'd2, 32'd15, 32'd1, 32'd1000);
    checks++;
    if (pix_cnt !== 32'd14) begin
      errors++; $display("FAIL pre_clear_pix_cnt got=%0d required=14", pix_cnt);
    end
    send_cmd(2'd2);
    pix_x = 16'd1; pix_y = 16'd2; pix_n = 32'd77; pix_min = 32'd1; pix_max = 32'd1000;
    pix_valid = 1'b1; cmd_op = 2'd1; cmd_valid = 1'b1;
    cnt = 0; rdy_bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
      if (pix_ready || cmd_ready) rdy_bad = 1'b1;
    end
    cmd_valid = 1'b0;
    checks++;
    if (cnt != 12 || rdy_bad !== 1'b0) begin
      errors++;
      $display("FAIL clear_busy cycles=%0d ready_seen=%0b required=12/0", cnt, rdy_bad);
    end
    checks++;
    if (pix_ready !== 1'b1 || pix_cnt !== 32'd0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL clear_first_idle pix_ready=%0b pix_cnt=%0d frame_done=%0b req=1/0/0",
               pix_ready, pix_cnt, frame_done);
    end
    @(posedge clk); #1;
    pix_valid = 1'b0;
    checks++;
    if (pix_cnt !== 32'd1 || frame_done !== 1'b0 || drop_cnt !== 16'hFFFF ||
        frame_cnt !== 16'd3) begin
      errors++;
      $display("FAIL clear_after pix_cnt=%0d done=%0b drop=%0h frames=%0d req=1/0/ffff/3",
               pix_cnt, frame_done, drop_cnt, frame_cnt);
    end
    for (int a = 0; a < 12; a++) begin
      rd(4'(a), d);
      exp = (a == 9) ? 10'd77 : 10'd0;
      checks++;
      if (d !== exp) begin
        errors++; $display("FAIL clear_mem addr=%0d got=%0d required=%0d", a, d, exp);
      end
    end
  endtask

  task automatic test_read_first();
    logic [9:0] d;
    @(negedge clk);
    pix_x = 16'd1; pix_y = 16'd2; pix_n = 32'd50; pix_min = 32'd1; pix_max = 32'd1000;
    pix_valid = 1'b1; rd_en = 1'b1; rd_addr = 4'd9;
    @(posedge clk); #1;
    pix_valid = 1'b0; rd_en = 1'b0;
    @(negedge clk);
    checks++;
    if (rd_data !== 10'd77) begin
      errors++; $display("FAIL read_first_old got=%0d required=77", rd_data);
    end
    rd(4'd9, d);
    checks++;
    if (d !== 10'd50 || pix_cnt !== 32'd2) begin
      errors++;
      $display("FAIL read_first_new got=%0d pix_cnt=%0d required=50/2", d, pix_cnt);
    end
  endtask

  function automatic logic [9:0] big_model(input int a);
    int n;
    n = (a % 200) + (a / 200);
    return (n < 1) ? 10'd0 : 10'(n);
  endfunction

  task automatic test_full_frame();
    int cyc, bad, rdy_bad, first_a;
    logic [9:0] first_got;
    cyc = 0;
    while (b_busy && cyc < 45000) begin
      @(negedge clk); cyc++;
    end
    checks++;
    if (b_busy) begin
      errors++; $display("FAIL full_frame_clear_timeout busy=%0b required=0", b_busy);
      return;
    end
    bad = 0; rdy_bad = 0; first_a = -1; first_got = '0;
    // Write pixel k while reading back pixel k-1 written the cycle before.
    for (int k = 0; k <= 40001; k++) begin
      @(negedge clk);
      if (k >= 2 && b_rd_data !== big_model(k - 2)) begin
        if (bad == 0) begin first_a = k - 2; first_got = b_rd_data; end
        bad++;
      end
      if (k < 40000) begin
        if (!b_pix_ready) rdy_bad++;
        b_pix_x = 16'(k % 200); b_pix_y = 16'(k / 200);
        b_pix_n = 32'(((k % 200) + (k / 200)) % 1000);
        b_pix_valid = 1'b1;
      end else begin
        b_pix_valid = 1'b0;
      end
      if (k >= 1 && k <= 40000) begin
        b_rd_en = 1'b1; b_rd_addr = 16'(k - 1);
      end else begin
        b_rd_en = 1'b0;
      end
    end
    checks++;
    if (bad != 0 || rdy_bad != 0) begin
      errors++;
      $display("FAIL full_frame_stream mismatches=%0d stalls=%0d first_addr=%0d got=%0d req=%0d",
               bad, rdy_bad, first_a, first_got, (first_a >= 0) ? big_model(first_a) : 10'd0);
    end
    @(negedge clk);
    b_cmd_op = 2'd1; b_cmd_valid = 1'b1;
    @(posedge clk); #1;
    b_cmd_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (b_pix_cnt !== 32'd40000 || b_frame_cnt !== 16'd1 || b_frame_done !== 1'b1) begin
      errors++;
      $display("FAIL full_frame_status pix_cnt=%0d frame_cnt=%0d done=%0b required=40000/1/1",
               b_pix_cnt, b_frame_cnt, b_frame_done);
    end
    bad = 0;
    for (int a = 0; a < 40000; a += 97) begin
      @(negedge clk);
      b_rd_en = 1'b1; b_rd_addr = 16'(a);
      @(posedge clk); #1;
      b_rd_en = 1'b0;
      @(negedge clk);
      if (b_rd_data !== big_model(a)) bad++;
    end
    @(negedge clk);
    b_rd_en = 1'b1; b_rd_addr = 16'd39999;
    @(posedge clk); #1;
    b_rd_en = 1'b0;
    @(negedge clk);
    if (b_rd_data !== big_model(39999)) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL full_frame_sweep mismatches=%0d required=0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_pixel_write();
    test_out_of_range();
    test_commands();
    test_collision();
    test_clear_midframe();
    test_read_first();
    test_full_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
